// File: rtl/pc_sequencer_pkg.sv
// Shared CPU front-end definitions: reset vector, sequencer state encoding
// and the kinds of control-flow redirect that decode can resolve.
package pc_sequencer_pkg;

    localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        RK_NONE   = 2'd0,
        RK_BRANCH = 2'd1,
        RK_JUMP   = 2'd2,
        RK_JR     = 2'd3
    } redirect_kind_t;

endpackage

// File: rtl/pc_sequencer_npc_target.sv
// Combinational next-PC target decode for branch / j / jal / jr resolutions.
// Priority is jr over jump over taken branch.
module npc_target
    import pc_sequencer_pkg::*;
(
    input  logic        resolve_valid,
    input  logic        branch,
    input  logic        equal,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_pc4,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic        redirect_valid,
    output logic [31:0] target,
    output logic        misalign
);

    redirect_kind_t kind;
    logic [31:0]    branch_target;

    always_comb begin
        kind = RK_NONE;
        if (resolve_valid) begin
            if (jr) begin
                kind = RK_JR;
            end else if (jump) begin
                kind = RK_JUMP;
            end else if (branch && equal) begin
                kind = RK_BRANCH;
            end
        end
    end

    // imm16 counts words, so the byte offset is the sign-extended value times four
    assign branch_target = br_pc4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = '0;
        case (kind)
            RK_BRANCH: target = branch_target;
            RK_JUMP:   target = {br_pc4[31:28], instr_index, 2'b00};
            RK_JR:     target = {jr_target[31:2], 2'b00};
            default:   target = '0;
        endcase
    end

    assign redirect_valid = (kind != RK_NONE);
    assign misalign       = (kind == RK_JR) && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the CPU front end.
// One fetch in flight at a time; redirects arriving between handshakes are parked.
//
//   state | meaning
//   BOOT  | out of reset, no request yet
//   FETCH | if_req high, waiting for if_ack
//   HOLD  | stalled after a completed fetch, PC frozen
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resolve_valid,
    input  logic              branch,
    input  logic              equal,
    input  logic              jump,
    input  logic              jr,
    input  logic [ADDR_W-1:0] br_pc4,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              stall,
    input  logic              if_ack,
    output logic              if_req,
    output logic [ADDR_W-1:0] if_addr,
    output logic              redirect,
    output logic              addr_err
);

    seq_state_t        state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic              pend_valid_q, pend_valid_next;
    logic [ADDR_W-1:0] pend_target_q, pend_target_next;
    logic              redirect_q, redirect_next;
    logic              addr_err_q, addr_err_next;

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_target;
    logic              rd_misalign;
    logic              handshake;

    npc_target u_npc_target (
        .resolve_valid  (resolve_valid),
        .branch         (branch),
        .equal          (equal),
        .jump           (jump),
        .jr             (jr),
        .br_pc4         (br_pc4),
        .imm16          (imm16),
        .instr_index    (instr_index),
        .jr_target      (jr_target),
        .redirect_valid (rd_valid),
        .target         (rd_target),
        .misalign       (rd_misalign)
    );

    assign handshake = (state == FETCH) && if_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            redirect_q    <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state         <= state_next;
            pc_q          <= pc_next;
            pend_valid_q  <= pend_valid_next;
            pend_target_q <= pend_target_next;
            redirect_q    <= redirect_next;
            addr_err_q    <= addr_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc_q;
        pend_valid_next  = pend_valid_q;
        pend_target_next = pend_target_q;
        redirect_next    = 1'b0;
        addr_err_next    = addr_err_q | rd_misalign;

        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (if_ack && stall) state_next = HOLD;
            HOLD:    if (!stall) state_next = FETCH;
            default: state_next = BOOT;
        endcase

        // A same-cycle redirect bypasses and supersedes anything already parked
        if (handshake) begin
            if (rd_valid) begin
                pc_next         = rd_target;
                pend_valid_next = 1'b0;
                redirect_next   = 1'b1;
            end else if (pend_valid_q) begin
                pc_next         = pend_target_q;
                pend_valid_next = 1'b0;
                redirect_next   = 1'b1;
            end else begin
                pc_next = pc_q + ADDR_W'(4);
            end
        end else if (rd_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = rd_target;
        end
    end

    assign if_req   = (state == FETCH);
    assign if_addr  = pc_q;
    assign redirect = redirect_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with fixed expected
// values, then randomized traffic compared against a behavioural front-end model.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        resolve_valid;
    logic        branch;
    logic        equal;
    logic        jump;
    logic        jr;
    logic [31:0] br_pc4;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic        stall;
    logic        if_ack;
    logic        if_req;
    logic [31:0] if_addr;
    logic        redirect;
    logic        addr_err;

    int passed;
    int total;

    // behavioural model: mode 0 = idle after reset, 1 = requesting, 2 = stalled
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pending[$];
    logic        m_redir;
    logic        m_err;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .resolve_valid (resolve_valid),
        .branch        (branch),
        .equal         (equal),
        .jump          (jump),
        .jr            (jr),
        .br_pc4        (br_pc4),
        .imm16         (imm16),
        .instr_index   (instr_index),
        .jr_target     (jr_target),
        .stall         (stall),
        .if_ack        (if_ack),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .redirect      (redirect),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_resolve();
        resolve_valid = 1'b0;
        branch        = 1'b0;
        equal         = 1'b0;
        jump          = 1'b0;
        jr            = 1'b0;
        br_pc4        = 32'h0;
        imm16         = 16'h0;
        instr_index   = 26'h0;
        jr_target     = 32'h0;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0000_3000;
        m_pending.delete();
        m_redir = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs now applied, then clock the DUT.
    task automatic tick();
        logic        have;
        logic [31:0] tgt;
        logic        fetch_done;
        longint      off;
        have = 1'b0;
        tgt  = 32'h0;
        if (resolve_valid) begin
            if (jr) begin
                have = 1'b1;
                tgt  = jr_target - (jr_target % 4);
                if (jr_target % 4 != 0) m_err = 1'b1;
            end else if (jump) begin
                have = 1'b1;
                tgt  = (br_pc4 & 32'hF000_0000) + 32'(instr_index) * 4;
            end else if (branch && equal) begin
                have = 1'b1;
                off  = longint'($signed(imm16)) * 4;
                tgt  = 32'(longint'(br_pc4) + off);
            end
        end
        fetch_done = (m_mode == 1) && if_ack;
        m_redir = 1'b0;
        if (fetch_done) begin
            if (have) begin
                m_pc = tgt;
                m_pending.delete();
                m_redir = 1'b1;
            end else if (m_pending.size() > 0) begin
                m_pc = m_pending[$];
                m_pending.delete();
                m_redir = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (have) begin
            m_pending.push_back(tgt);
        end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && fetch_done && stall) m_mode = 2;
        else if (m_mode == 2 && !stall) m_mode = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_resolve();
        stall  = 1'b0;
        if_ack = 1'b0;
        model_reset();
        #12;
        total++;
        if ({if_req, redirect, addr_err, if_addr} !== {1'b0, 1'b0, 1'b0, 32'h0000_3000}) begin
            $display("FAIL reset_state: got req=%b redir=%b err=%b addr=%h want 0 0 0 00003000",
                     if_req, redirect, addr_err, if_addr);
        end else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        total++;
        if (if_req !== 1'b0) $display("FAIL boot_no_req: got req=%b want 0", if_req);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr[3];
        exp_addr[0] = 32'h0000_3000;
        exp_addr[1] = 32'h0000_3004;
        exp_addr[2] = 32'h0000_3008;
        if_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({if_req, redirect, if_addr} !== {1'b1, 1'b0, exp_addr[i]}) begin
                $display("FAIL seq_fetch_%0d: got req=%b redir=%b addr=%h want 1 0 %h",
                         i, if_req, redirect, if_addr, exp_addr[i]);
            end else passed++;
        end
    endtask

    task automatic test_branch();
        resolve_valid = 1'b1;
        branch = 1'b1;
        equal  = 1'b1;
        br_pc4 = 32'h0000_3008;
        imm16  = 16'hFFFE;
        tick();
        total++;
        if ({redirect, if_addr} !== {1'b1, 32'h0000_3000}) begin
            $display("FAIL branch_taken: got redir=%b addr=%h want 1 00003000", redirect, if_addr);
        end else passed++;
        clear_resolve();
        tick();
        total++;
        if ({redirect, if_addr} !== {1'b0, 32'h0000_3004}) begin
            $display("FAIL redirect_one_cycle: got redir=%b addr=%h want 0 00003004", redirect, if_addr);
        end else passed++;
        tick();
        resolve_valid = 1'b1;
        branch = 1'b1;
        equal  = 1'b0;
        br_pc4 = 32'h0000_3008;
        imm16  = 16'hFFFE;
        tick();
        total++;
        if ({redirect, if_addr} !== {1'b0, 32'h0000_300C}) begin
            $display("FAIL branch_not_taken: got redir=%b addr=%h want 0 0000300c", redirect, if_addr);
        end else passed++;
        clear_resolve();
    endtask

    task automatic test_jump_wait();
        if_ack        = 1'b0;
        resolve_valid = 1'b1;
        jump          = 1'b1;
        br_pc4        = 32'h0000_3010;
        instr_index   = 26'h0000C40;
        for (int i = 0; i < 3; i++) begin
            tick();
            clear_resolve();
            total++;
            if ({if_req, redirect, if_addr} !== {1'b1, 1'b0, 32'h0000_300C}) begin
                $display("FAIL jump_wait_%0d: got req=%b redir=%b addr=%h want 1 0 0000300c",
                         i, if_req, redirect, if_addr);
            end else passed++;
        end
        if_ack = 1'b1;
        tick();
        total++;
        if ({redirect, if_addr} !== {1'b1, 32'h0000_3100}) begin
            $display("FAIL jump_pending: got redir=%b addr=%h want 1 00003100", redirect, if_addr);
        end else passed++;
    endtask

    task automatic test_latest_wins();
        if_ack        = 1'b0;
        resolve_valid = 1'b1;
        branch        = 1'b1;
        equal         = 1'b1;
        br_pc4        = 32'h0000_3104;
        imm16         = 16'h0004;
        tick();
        clear_resolve();
        resolve_valid = 1'b1;
        jr            = 1'b1;
        jr_target     = 32'h0000_4001;
        tick();
        clear_resolve();
        total++;
        if ({addr_err, if_addr} !== {1'b1, 32'h0000_3100}) begin
            $display("FAIL jr_misalign: got err=%b addr=%h want 1 00003100", addr_err, if_addr);
        end else passed++;
        if_ack = 1'b1;
        tick();
        total++;
        if ({redirect, addr_err, if_addr} !== {1'b1, 1'b1, 32'h0000_4000}) begin
            $display("FAIL latest_wins: got redir=%b err=%b addr=%h want 1 1 00004000",
                     redirect, addr_err, if_addr);
        end else passed++;
    endtask

    task automatic test_stall_wrap();
        if_ack = 1'b1;
        stall  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({if_req, if_addr} !== {1'b0, 32'h0000_4004}) begin
                $display("FAIL stall_hold_%0d: got req=%b addr=%h want 0 00004004", i, if_req, if_addr);
            end else passed++;
        end
        stall = 1'b0;
        tick();
        total++;
        if ({if_req, if_addr} !== {1'b1, 32'h0000_4004}) begin
            $display("FAIL stall_release: got req=%b addr=%h want 1 00004004", if_req, if_addr);
        end else passed++;
        resolve_valid = 1'b1;
        jr            = 1'b1;
        jr_target     = 32'hFFFF_FFFC;
        tick();
        clear_resolve();
        tick();
        total++;
        if ({if_req, addr_err, if_addr} !== {1'b1, 1'b1, 32'h0000_0000}) begin
            $display("FAIL pc_wrap: got req=%b err=%b addr=%h want 1 1 00000000", if_req, addr_err, if_addr);
        end else passed++;
    endtask

    task automatic test_reset_midfetch();
        if_ack        = 1'b0;
        resolve_valid = 1'b1;
        jump          = 1'b1;
        instr_index   = 26'h0000100;
        tick();
        clear_resolve();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({if_req, redirect, addr_err, if_addr} !== {1'b0, 1'b0, 1'b0, 32'h0000_3000}) begin
            $display("FAIL async_reset: got req=%b redir=%b err=%b addr=%h want 0 0 0 00003000",
                     if_req, redirect, addr_err, if_addr);
        end else passed++;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        if_ack = 1'b1;
        tick();
        tick();
        total++;
        if ({if_req, redirect, if_addr} !== {1'b1, 1'b0, 32'h0000_3004}) begin
            $display("FAIL pending_lost: got req=%b redir=%b addr=%h want 1 0 00003004",
                     if_req, redirect, if_addr);
        end else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            resolve_valid = ($urandom_range(0, 1) == 1);
            branch        = ($urandom_range(0, 1) == 1);
            equal         = ($urandom_range(0, 1) == 1);
            jump          = ($urandom_range(0, 3) == 0);
            jr            = ($urandom_range(0, 4) == 0);
            br_pc4        = $urandom();
            imm16         = 16'($urandom());
            instr_index   = 26'($urandom());
            jr_target     = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) jr_target[1:0] = 2'($urandom_range(1, 3));
            stall         = ($urandom_range(0, 3) == 0);
            if_ack        = ($urandom_range(0, 9) < 6);
            tick();
            total++;
            if ({if_req, redirect, addr_err, if_addr} !== {(m_mode == 1), m_redir, m_err, m_pc}) begin
                $display("FAIL random_%0d: got req=%b redir=%b err=%b addr=%h want %b %b %b %h",
                         i, if_req, redirect, addr_err, if_addr, (m_mode == 1), m_redir, m_err, m_pc);
            end else passed++;
        end
        clear_resolve();
        stall  = 1'b0;
        if_ack = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_wait();
        test_latest_wins();
        test_stall_wrap();
        test_reset_midfetch();
        apply_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
